bp_core_cache_req_arb: RTL

N-way cache-request arbiter between a core's L1 caches and a single LCE request port, generalising the fixed two-channel split (index 0 = icache, index 1 = dcache). It round-robin-arbitrates `num_caches_p` request channels and steers each granted request's trailing metadata beat to the same downstream port. It tracks one outstanding miss per channel and routes `complete_i` back to the owning cache by ID. It sits inside the core top, between the FE/BE cache-request outputs and the LCE.

---
 rtl/bp_common_pkg.sv | 17 +
 rtl/bsg_arb_round_robin.sv | 48 ++++
 rtl/bp_core_cache_req_arb.sv | 97 +++++++++
 3 files changed

// File: rtl/bp_common_pkg.sv
// Shared types and widths for the core cache request arbiter.
// Holds the arbiter FSM states and default payload widths.
`ifndef BSG_SAFE_CLOG2
`define BSG_SAFE_CLOG2(x) (((x) <= 1) ? 1 : $clog2(x))
`endif

package bp_common_pkg;

   localparam int cache_req_width_lp          = 72;
   localparam int cache_req_metadata_width_lp = 8;

   typedef enum logic {
      e_ready = 1'b0,
      e_meta  = 1'b1
   } bp_cache_req_arb_state_e;

endpackage

// File: rtl/bsg_arb_round_robin.sv
// Round-robin arbiter; priority starts just after the last granted index.
// The pointer only advances when the grant is actually taken (yumi_i).
module bsg_arb_round_robin
   #(parameter int width_p = 2
   , localparam int tag_width_lp = `BSG_SAFE_CLOG2(width_p))
   (input  logic                    clk_i
   , input  logic                    reset_i
   , input  logic [width_p-1:0]      reqs_i
   , output logic [width_p-1:0]      grants_o
   , output logic                    v_o
   , output logic [tag_width_lp-1:0] tag_o
   , input  logic                    yumi_i
   );

   logic [tag_width_lp-1:0] last_r;
   logic [tag_width_lp-1:0] idx;
   logic                    found;

   // Scan from last_r+1 upward with wrap, take the first requester.
   always_comb begin
      grants_o = '0;
      tag_o    = '0;
      found    = 1'b0;
      idx      = last_r;
      for (int k = 0; k < width_p; k++) begin
         if (idx == tag_width_lp'(width_p-1))
            idx = '0;
         else
            idx = idx + 1'b1;
         if (!found && reqs_i[idx]) begin
            found         = 1'b1;
            tag_o         = idx;
            grants_o[idx] = 1'b1;
         end
      end
   end

   assign v_o = found;

   // Reset gives channel 0 first priority.
   always_ff @(posedge clk_i) begin
      if (reset_i)
         last_r <= tag_width_lp'(width_p-1);
      else if (yumi_i)
         last_r <= tag_o;
   end

endmodule

// File: rtl/bp_core_cache_req_arb.sv
// N-way cache request arbiter in front of a single LCE request port.
// Grants a request, forwards its metadata beat, routes completions back.
module bp_core_cache_req_arb
   import bp_common_pkg::*;
   #(parameter int num_caches_p     = 2
   , parameter int req_width_p      = cache_req_width_lp
   , parameter int metadata_width_p = cache_req_metadata_width_lp
   , localparam int id_width_lp     = `BSG_SAFE_CLOG2(num_caches_p))
   (input  logic                                            clk_i
   , input  logic                                            reset_i
   , input  logic [num_caches_p-1:0][req_width_p-1:0]        cache_req_i
   , input  logic [num_caches_p-1:0]                         cache_req_v_i
   , output logic [num_caches_p-1:0]                         cache_req_ready_o
   , input  logic [num_caches_p-1:0][metadata_width_p-1:0]   cache_req_metadata_i
   , input  logic [num_caches_p-1:0]                         cache_req_metadata_v_i
   , output logic [num_caches_p-1:0]                         cache_req_complete_o
   , output logic [req_width_p-1:0]                          req_o
   , output logic                                            req_v_o
   , output logic [id_width_lp-1:0]                          req_id_o
   , input  logic                                            req_ready_i
   , output logic [metadata_width_p-1:0]                     metadata_o
   , output logic                                            metadata_v_o
   , input  logic                                            complete_i
   , input  logic [id_width_lp-1:0]                          complete_id_i
   );

   bp_cache_req_arb_state_e state_r;
   logic [id_width_lp-1:0]  owner_r;
   logic [num_caches_p-1:0] outstanding_r;

   logic [num_caches_p-1:0] eligible;
   logic [num_caches_p-1:0] arb_reqs;
   logic [num_caches_p-1:0] arb_grants;
   logic                    arb_v;
   logic [id_width_lp-1:0]  arb_tag;
   logic [num_caches_p-1:0] complete_oh;
   logic                    meta_phase;

   // A channel with a miss in flight cannot issue another request.
   assign eligible = cache_req_v_i & ~outstanding_r;
   assign arb_reqs = (!reset_i && state_r == e_ready && req_ready_i)
                   ? eligible : '0;

   bsg_arb_round_robin #(
      .width_p (num_caches_p)
   ) rr (
      .clk_i    (clk_i)
      ,.reset_i  (reset_i)
      ,.reqs_i   (arb_reqs)
      ,.grants_o (arb_grants)
      ,.v_o      (arb_v)
      ,.tag_o    (arb_tag)
      ,.yumi_i   (arb_v & req_ready_i)
   );

   assign cache_req_ready_o = arb_grants;
   assign req_v_o           = arb_v;
   assign req_id_o          = arb_tag;
   assign req_o             = arb_v ? cache_req_i[arb_tag] : '0;

   // Metadata is steered from the owner only; other channels are ignored.
   assign meta_phase   = !reset_i && (state_r == e_meta);
   assign metadata_v_o = meta_phase & cache_req_metadata_v_i[owner_r];
   assign metadata_o   = meta_phase ? cache_req_metadata_i[owner_r] : '0;

   // Decode the completion ID into a per-channel pulse.
   always_comb begin
      complete_oh = '0;
      for (int i = 0; i < num_caches_p; i++)
         if (!reset_i && complete_i && complete_id_i == id_width_lp'(i))
            complete_oh[i] = 1'b1;
   end

   assign cache_req_complete_o = complete_oh;

   // Request/metadata FSM plus per-channel outstanding tracking.
   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         state_r       <= e_ready;
         owner_r       <= '0;
         outstanding_r <= '0;
      end else begin
         outstanding_r <= (outstanding_r & ~complete_oh) | arb_grants;
         unique case (state_r)
            e_ready:
               if (arb_v) begin
                  state_r <= e_meta;
                  owner_r <= arb_tag;
               end
            e_meta:
               if (metadata_v_o)
                  state_r <= e_ready;
         endcase
      end
   end

endmodule
